// File: rtl/toggle_pulse_decoder_pkg.sv
// toggle_pulse_decoder_pkg
// Shared types and constants for the toggle-line receive decoder.
//   dec_state_e     : decoder FSM states (INIT, RUN)
//   MAX_SYNC_STAGES : deepest synchroniser the decoder will build
//   max_count()     : saturation value of a pending counter of a given width
package toggle_pulse_decoder_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } dec_state_e;

    localparam int MAX_SYNC_STAGES = 4;

    function automatic int max_count(input int cnt_w);
        return (1 << cnt_w) - 1;
    endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// sync_ff_chain
// Multi-flop level synchroniser for a single asynchronous bit.
//   clk : destination clock, rising edge
//   rst : asynchronous reset, active-high, clears every stage to 0
//   d   : asynchronous input bit
//   q   : synchronised output (last stage)
module sync_ff_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/toggle_pulse_decoder.sv
// toggle_pulse_decoder
// Receive end of a toggle-signalled crossing: each level change on tog_in is
// one event. Events are queued in a saturating counter and offered through a
// valid/ready handshake.
//   clk      : local clock, rising edge
//   rst      : asynchronous reset, active-high
//   tog_in   : toggle line from the sender (asynchronous)
//   ev_valid : at least one event pending
//   ev_ready : consumer takes one event when ev_valid && ev_ready
//   pending  : current pending-event count
//   ovf      : sticky, an event was dropped with the counter full
//   ovf_clr  : synchronous clear of ovf (a same-edge set wins)
//   primed   : reference level captured, decoding active
// Optional build macro TOGGLE_PULSE_DECODER_GLITCH_FILTER_EN adds a
// two-sample agreement filter after the synchroniser (+1 latency, +1 INIT).
//
// state | meaning
// ------+---------------------------------------------------------------
// INIT  | counting edges after reset; last edge captures reference level
// RUN   | decoding: event = filtered line XOR previous sample
module toggle_pulse_decoder
    import toggle_pulse_decoder_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tog_in,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [CNT_W-1:0] pending,
    output logic             ovf,
    input  logic             ovf_clr,
    output logic             primed
);

    // Out-of-range depths are clamped to the legal 2..MAX_SYNC_STAGES.
    localparam int SYNC_N = (SYNC_STAGES > MAX_SYNC_STAGES) ? MAX_SYNC_STAGES :
                            (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
`ifdef TOGGLE_PULSE_DECODER_GLITCH_FILTER_EN
    localparam int INIT_LEN = SYNC_N + 2;
`else
    localparam int INIT_LEN = SYNC_N + 1;
`endif
    localparam int PCW = 3;
    localparam logic [PCW-1:0]   PRIME_LAST = PCW'(INIT_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(max_count(CNT_W));

    logic sync_out;
    logic dec_in;

    sync_ff_chain #(.STAGES(SYNC_N)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (tog_in),
        .q   (sync_out)
    );

`ifdef TOGGLE_PULSE_DECODER_GLITCH_FILTER_EN
    // A new level passes only once two consecutive samples agree; otherwise
    // the last accepted level is held.
    logic sync_last_q;
    logic filt_q;
    logic filt_d;

    always_comb begin
        filt_d = (sync_out == sync_last_q) ? sync_out : filt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_last_q <= 1'b0;
            filt_q      <= 1'b0;
        end else begin
            sync_last_q <= sync_out;
            filt_q      <= filt_d;
        end
    end

    assign dec_in = filt_d;
`else
    assign dec_in = sync_out;
`endif

    dec_state_e       state_q, state_d;
    logic [PCW-1:0]   prime_cnt_q, prime_cnt_d;
    logic             prev_q, prev_d;
    logic             primed_q, primed_d;
    logic [CNT_W-1:0] pending_q, pending_d;
    logic             ovf_q, ovf_d;
    logic             ev;
    logic             take;
    logic             ovf_set;

    assign ev_valid = (pending_q != '0);
    assign take     = ev_valid && ev_ready;

    always_comb begin
        state_d     = state_q;
        prime_cnt_d = prime_cnt_q;
        prev_d      = prev_q;
        primed_d    = primed_q;
        pending_d   = pending_q;
        ovf_set     = 1'b0;
        ev          = 1'b0;

        case (state_q)
            INIT: begin
                if (prime_cnt_q == PRIME_LAST) begin
                    prev_d   = dec_in;
                    primed_d = 1'b1;
                    state_d  = RUN;
                end else begin
                    prime_cnt_d = prime_cnt_q + 1'b1;
                end
            end
            RUN: begin
                ev     = dec_in ^ prev_q;
                prev_d = dec_in;
            end
            default: state_d = INIT;
        endcase

        // An event arriving with a take cancels out, so it cannot overflow.
        case ({ev, take})
            2'b10: begin
                if (pending_q == CNT_MAX) begin
                    ovf_set = 1'b1;
                end else begin
                    pending_d = pending_q + 1'b1;
                end
            end
            2'b01:   pending_d = pending_q - 1'b1;
            default: ;
        endcase

        ovf_d = ovf_set | (ovf_q & ~ovf_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= INIT;
            prime_cnt_q <= '0;
            prev_q      <= 1'b0;
            primed_q    <= 1'b0;
            pending_q   <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            prime_cnt_q <= prime_cnt_d;
            prev_q      <= prev_d;
            primed_q    <= primed_d;
            pending_q   <= pending_d;
            ovf_q       <= ovf_d;
        end
    end

    assign pending = pending_q;
    assign ovf     = ovf_q;
    assign primed  = primed_q;

endmodule

// File: tb/tb_toggle_pulse_decoder.sv
module tb_toggle_pulse_decoder;

`ifdef TOGGLE_PULSE_DECODER_GLITCH_FILTER_EN
    localparam int LAT      = 4;
    localparam int INIT_LEN = 4;
    localparam int GLITCH_EVENTS = 0;
`else
    localparam int LAT      = 3;
    localparam int INIT_LEN = 3;
    localparam int GLITCH_EVENTS = 2;
`endif

    logic       clk;
    logic       rst;
    logic       tog_in;
    logic       ev_valid;
    logic       ev_ready;
    logic [3:0] pending;
    logic       ovf;
    logic       ovf_clr;
    logic       primed;

    int n_cmp  = 0;
    int n_fail = 0;

    toggle_pulse_decoder #(.SYNC_STAGES(2), .CNT_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .tog_in   (tog_in),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .pending  (pending),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr),
        .primed   (primed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit tgl;
        bit rdy;
        bit clr;
        int exp_pend;
        bit exp_ovf;
    } vec_t;

    vec_t vecs[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial begin
        int p;
        bit ev_at [0:40];

        vecs[0] = '{1, 0, 0, 1, 0};
        vecs[1] = '{1, 0, 0, 2, 0};
        vecs[2] = '{1, 0, 0, 3, 0};
        vecs[3] = '{0, 1, 0, 2, 0};
        vecs[4] = '{1, 1, 0, 2, 0};
        vecs[5] = '{0, 1, 0, 1, 0};
        vecs[6] = '{0, 1, 0, 0, 0};
        vecs[7] = '{0, 1, 0, 0, 0};
        vecs[8] = '{0, 0, 1, 0, 0};

        // Reset with the sender sitting at level 1.
        rst = 1'b1; tog_in = 1'b1; ev_ready = 1'b0; ovf_clr = 1'b0;
        tick(); tick();
        chk("rst_pending", int'(pending), 0);
        chk("rst_valid", int'(ev_valid), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_primed", int'(primed), 0);
        rst = 1'b0;
        for (int i = 0; i < INIT_LEN - 1; i++) tick();
        chk("init_not_primed", int'(primed), 0);
        tick();
        chk("init_primed", int'(primed), 1);
        for (int i = 0; i < 4; i++) tick();
        chk("init_no_event_valid", int'(ev_valid), 0);
        chk("init_no_event_pend", int'(pending), 0);

        // Single event latency, then consume it.
        tog_in = ~tog_in;
        for (int i = 0; i < LAT - 1; i++) tick();
        chk("lat_early_pend", int'(pending), 0);
        tick();
        chk("lat_pend", int'(pending), 1);
        chk("lat_valid", int'(ev_valid), 1);
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
        chk("take_pend", int'(pending), 0);
        chk("take_valid", int'(ev_valid), 0);

        // Table: one-edge stimulus, then settle long enough for any event.
        for (int v = 0; v < 9; v++) begin
            if (vecs[v].tgl) tog_in = ~tog_in;
            ev_ready = vecs[v].rdy;
            ovf_clr  = vecs[v].clr;
            tick();
            ev_ready = 1'b0;
            ovf_clr  = 1'b0;
            for (int i = 0; i < 4; i++) tick();
            chk($sformatf("vec%0d_pend", v), int'(pending), vecs[v].exp_pend);
            chk($sformatf("vec%0d_valid", v), int'(ev_valid), int'(vecs[v].exp_pend != 0));
            chk($sformatf("vec%0d_ovf", v), int'(ovf), int'(vecs[v].exp_ovf));
        end

        // Saturation at 15 and overflow.
        for (int t = 0; t < 15; t++) begin
            tog_in = ~tog_in;
            for (int i = 0; i < 4; i++) tick();
        end
        chk("sat15_pend", int'(pending), 15);
        chk("sat15_ovf", int'(ovf), 0);
        tog_in = ~tog_in;
        for (int i = 0; i < 4; i++) tick();
        chk("sat16_pend", int'(pending), 15);
        chk("sat16_ovf", int'(ovf), 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovfclr_ovf", int'(ovf), 0);
        chk("ovfclr_pend", int'(pending), 15);

        // Overflow and clear on the same edge: set wins.
        tog_in = ~tog_in;
        for (int i = 0; i < LAT - 1; i++) tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("setwins_ovf", int'(ovf), 1);
        chk("setwins_pend", int'(pending), 15);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("setwins_clr_ovf", int'(ovf), 0);

        // Drain from 15 with ready held; toggles every 4 clocks.
        for (int i = 0; i <= 40; i++) ev_at[i] = 1'b0;
        for (int k = 0; k <= 12; k += 4) ev_at[k + LAT] = 1'b1;
        p = 15;
        ev_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            bit tk;
            if ((k % 4) == 0 && k <= 12) tog_in = ~tog_in;
            tick();
            tk = (p != 0);
            if (ev_at[k + 1] && !tk) p = p + 1;
            else if (!ev_at[k + 1] && tk) p = p - 1;
            chk($sformatf("drain%0d_pend", k), int'(pending), p);
            chk($sformatf("drain%0d_ovf", k), int'(ovf), 0);
        end
        ev_ready = 1'b0;

        // Glitch of one clock on the raw line.
        tog_in = ~tog_in;
        tick();
        tog_in = ~tog_in;
        for (int i = 0; i < 6; i++) tick();
        chk("glitch_pend", int'(pending), GLITCH_EVENTS);
        ev_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        ev_ready = 1'b0;
        chk("glitch_drain", int'(pending), 0);

        // Build up 5 events, reset mid-stream, toggle during INIT.
        for (int t = 0; t < 5; t++) begin
            tog_in = ~tog_in;
            for (int i = 0; i < 4; i++) tick();
        end
        chk("pre_rst_pend", int'(pending), 5);
        rst = 1'b1;
        tick(); tick();
        chk("midrst_pend", int'(pending), 0);
        chk("midrst_primed", int'(primed), 0);
        rst = 1'b0;
        tog_in = ~tog_in;
        for (int i = 0; i < INIT_LEN + 6; i++) tick();
        chk("post_rst_pend", int'(pending), 0);
        chk("post_rst_valid", int'(ev_valid), 0);
        chk("post_rst_ovf", int'(ovf), 0);
        chk("post_rst_primed", int'(primed), 1);

        // Decoding resumes after re-priming.
        tog_in = ~tog_in;
        for (int i = 0; i < LAT; i++) tick();
        chk("resume_pend", int'(pending), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
